// File: rtl/uart_serial_rx_monitor.sv
// uart_serial_rx_monitor: 16x oversampled 8N1 receiver into a FWFT FIFO; UART_RX_MONITOR_PARITY_EN adds a parity bit
module uart_serial_rx_monitor #(
  parameter int FIFO_AW = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clock,
  input  logic             wb_rst_i,
  input  logic             rx_i,
  input  logic [15:0]      divisor_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             framing_err_o,
  output logic             overrun_o,
  input  logic             clr_i,
`ifdef UART_RX_MONITOR_PARITY_EN
  input  logic             parity_odd_i,
  output logic             parity_err_o,
`endif
  output logic [FIFO_AW:0] count_o
);
  localparam int DEPTH = 2 ** FIFO_AW;
`ifdef UART_RX_MONITOR_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic rxs, tick, push, ferr_n, bad_par, pop, full, wr, ovr;
  logic [15:0] tcnt;
  logic [3:0] sc, sc_n;
  logic [2:0] bidx, bidx_n;
  logic [7:0] shift, shift_n;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] cnt;
  assign rxs = sync_q[SYNC_STAGES-1];
  assign tick = tcnt == 16'd0;
`ifdef UART_RX_MONITOR_PARITY_EN
  logic par_q, par_n, perr_n;
  assign bad_par = par_q != (^shift ^ parity_odd_i);
`else
  assign bad_par = 1'b0;
`endif
  // rx synchroniser, idles high
  always_ff @(posedge wb_clock or posedge wb_rst_i)
    if (wb_rst_i) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  // free-running 1/16-bit tick; a new divisor is picked up only at reload
  always_ff @(posedge wb_clock or posedge wb_rst_i)
    if (wb_rst_i) tcnt <= 16'd0;
    else tcnt <= tick ? (divisor_i == 16'd0 ? 16'd0 : divisor_i - 16'd1) : tcnt - 16'd1;
  // deframer state and datapath registers
  always_ff @(posedge wb_clock or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      sc <= 4'd0;
      bidx <= 3'd0;
      shift <= 8'd0;
      framing_err_o <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_q <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sc <= sc_n;
      bidx <= bidx_n;
      shift <= shift_n;
      framing_err_o <= ferr_n;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_q <= par_n;
      parity_err_o <= perr_n;
`endif
    end
  // next-state: start detect, mid-bit start check, data/parity/stop sampling at sc==15
  always_comb begin
    state_n = state;
    sc_n = tick ? sc + 4'd1 : sc;
    bidx_n = bidx;
    shift_n = shift;
    push = 1'b0;
    ferr_n = 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
    par_n = par_q;
    perr_n = 1'b0;
`endif
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        sc_n = 4'd0;
      end
      START: if (tick && sc == 4'd7) begin
        state_n = rxs ? IDLE : DATA;
        sc_n = 4'd0;
        bidx_n = 3'd0;
      end
      DATA: if (tick && sc == 4'd15) begin
        shift_n = {rxs, shift[7:1]};
        bidx_n = bidx + 3'd1;
        sc_n = 4'd0;
`ifdef UART_RX_MONITOR_PARITY_EN
        if (bidx == 3'd7) state_n = PARITY;
      end
      PARITY: if (tick && sc == 4'd15) begin
        par_n = rxs;
        sc_n = 4'd0;
        state_n = STOP;
`else
        if (bidx == 3'd7) state_n = STOP;
`endif
      end
      STOP: if (tick && sc == 4'd15) begin
        ferr_n = !rxs;
        push = rxs && !bad_par;
`ifdef UART_RX_MONITOR_PARITY_EN
        perr_n = bad_par;
`endif
        state_n = rxs ? IDLE : BREAK;
      end
      BREAK: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign pop = valid_o && ready_i;
  assign full = cnt == (FIFO_AW + 1)'(DEPTH);
  assign wr = push && (!full || pop);
  assign ovr = push && full && !pop;
  assign valid_o = cnt != '0;
  assign data_o = valid_o ? mem[rp] : 8'd0;
  assign count_o = cnt;
  // FIFO storage, no reset needed since data_o is masked by valid_o
  always_ff @(posedge wb_clock)
    if (wr) mem[wp] <= shift;
  // FIFO pointers, occupancy and sticky overrun (set beats clear)
  always_ff @(posedge wb_clock or posedge wb_rst_i)
    if (wb_rst_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overrun_o <= 1'b0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (FIFO_AW + 1)'(wr) - (FIFO_AW + 1)'(pop);
      overrun_o <= ovr | (overrun_o & ~clr_i);
    end
endmodule

// File: tb/tb_uart_serial_rx_monitor.sv
// tb_uart_serial_rx_monitor: directed vector bench for the UART receive monitor
module tb_uart_serial_rx_monitor;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b0, clr = 1'b0;
  logic [15:0] divisor = 16'd1;
  logic [7:0] data;
  logic valid, ferr, ovr;
  logic [3:0] count;
  int checks = 0, failures = 0, ferr_cnt = 0;
  logic [7:0] popped [$];
`ifdef UART_RX_MONITOR_PARITY_EN
  logic parity_odd = 1'b0, perr;
  int perr_cnt = 0;
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int STOP_IDX = 10 + 16 * (NB - 1);
  typedef struct {
    logic [7:0] d;
    logic stop;
    int pops;
    int ferrs;
  } vec_t;
  vec_t vecs [6];
  uart_serial_rx_monitor dut (
    .wb_clock(clk),
    .wb_rst_i(rst),
    .rx_i(rx),
    .divisor_i(divisor),
    .data_o(data),
    .valid_o(valid),
    .ready_i(ready),
    .framing_err_o(ferr),
    .overrun_o(ovr),
    .clr_i(clr),
`ifdef UART_RX_MONITOR_PARITY_EN
    .parity_odd_i(parity_odd),
    .parity_err_o(perr),
`endif
    .count_o(count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && valid && ready) popped.push_back(data);
    if (ferr) ferr_cnt++;
`ifdef UART_RX_MONITOR_PARITY_EN
    if (perr) perr_cnt++;
`endif
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_bits(input logic [10:0] bits, input int nb, input logic rdy_pulse, input int hold);
    for (int i = 0; i < nb * 16; i++) begin
      rx = bits[i / 16];
      if (rdy_pulse) ready = (i == STOP_IDX);
      step();
    end
    repeat (hold) step();
    rx = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rdy_pulse, input int hold);
    logic [10:0] b;
`ifdef UART_RX_MONITOR_PARITY_EN
    b = {stop, ^d ^ parity_odd, d, 1'b0};
`else
    b = {1'b1, stop, d, 1'b0};
`endif
    send_bits(b, NB, rdy_pulse, hold);
  endtask
  initial begin
    int bp, bf;
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 0};
    vecs[4] = '{8'hC3, 1'b0, 0, 1};
    vecs[5] = '{8'h01, 1'b1, 1, 0};
    step(3);
    chk("reset data_o", data, 8'h00);
    chk("reset valid_o", valid, 0);
    chk("reset framing_err_o", ferr, 0);
    chk("reset overrun_o", ovr, 0);
    chk("reset count_o", count, 0);
    rst = 1'b0;
    step(4);
    ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      bp = popped.size();
      bf = ferr_cnt;
      send_frame(vecs[v].d, vecs[v].stop, 1'b0, 0);
      step(24);
      chk($sformatf("vec%0d pops", v), popped.size() - bp, vecs[v].pops);
      if (popped.size() > bp) chk($sformatf("vec%0d data", v), popped[bp], vecs[v].d);
      chk($sformatf("vec%0d framing", v), ferr_cnt - bf, vecs[v].ferrs);
      chk($sformatf("vec%0d count", v), count, 0);
    end
    bp = popped.size();
    bf = ferr_cnt;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(24);
    chk("glitch pops", popped.size() - bp, 0);
    chk("glitch framing", ferr_cnt - bf, 0);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    step(24);
    chk("after glitch pops", popped.size() - bp, 1);
    if (popped.size() > bp) chk("after glitch data", popped[bp], 8'h3C);
    bp = popped.size();
    bf = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 100);
    step(24);
    chk("break framing pulses", ferr_cnt - bf, 1);
    chk("break pops", popped.size() - bp, 0);
    chk("break count", count, 0);
    send_frame(8'h0F, 1'b1, 1'b0, 0);
    step(24);
    chk("after break pops", popped.size() - bp, 1);
    if (popped.size() > bp) chk("after break data", popped[bp], 8'h0F);
    chk("after break framing", ferr_cnt - bf, 1);
    ready = 1'b0;
    bp = popped.size();
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b1, 1'b0, 0);
      step(4);
    end
    chk("overrun count", count, 8);
    chk("overrun flag", ovr, 1);
    chk("overrun head", data, 8'h01);
    ready = 1'b1;
    step(12);
    ready = 1'b0;
    chk("overrun drained", popped.size() - bp, 8);
    for (int k = 0; k < 8; k++)
      if (popped.size() > bp + k) chk($sformatf("overrun order %0d", k), popped[bp + k], 8'(k + 1));
    chk("overrun sticky", ovr, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("overrun cleared", ovr, 0);
    bp = popped.size();
    for (int k = 1; k <= 8; k++) begin
      send_frame(8'(k), 1'b1, 1'b0, 0);
      step(4);
    end
    chk("full count", count, 8);
    send_frame(8'h09, 1'b1, 1'b1, 0);
    step(4);
    chk("full push+pop overrun", ovr, 0);
    chk("full push+pop count", count, 8);
    ready = 1'b1;
    step(12);
    ready = 1'b0;
    chk("full drained", popped.size() - bp, 9);
    if (popped.size() > bp) chk("full first", popped[bp], 8'h01);
    if (popped.size() > 0) chk("full last", popped[popped.size() - 1], 8'h09);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    step(4);
    chk("pre-reset count", count, 1);
    for (int i = 0; i < 88; i++) begin
      rx = i < 16 ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1;
    #1;
    chk("midreset data_o", data, 8'h00);
    chk("midreset valid_o", valid, 0);
    chk("midreset count_o", count, 0);
    chk("midreset framing", ferr, 0);
    chk("midreset overrun", ovr, 0);
    step(3);
    rst = 1'b0;
    step(80);
    ready = 1'b1;
    bp = popped.size();
    bf = ferr_cnt;
    send_frame(8'h81, 1'b1, 1'b0, 0);
    step(24);
    chk("post-reset pops", popped.size() - bp, 1);
    if (popped.size() > bp) chk("post-reset data", popped[bp], 8'h81);
    chk("post-reset framing", ferr_cnt - bf, 0);
`ifdef UART_RX_MONITOR_PARITY_EN
    begin
      int bpe;
      bp = popped.size();
      bpe = perr_cnt;
      send_bits({1'b1, 1'b0, 8'h07, 1'b0}, NB, 1'b0, 0);
      step(24);
      chk("parity err pulses", perr_cnt - bpe, 1);
      chk("parity err pops", popped.size() - bp, 0);
      send_frame(8'h07, 1'b1, 1'b0, 0);
      step(24);
      chk("parity ok pops", popped.size() - bp, 1);
      chk("parity ok pulses", perr_cnt - bpe, 1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_serial_rx_monitor.md
Name: uart_serial_rx_monitor

Overview:
- Serial receiver that consumes the UART core's TX line in the block-level bench.
- Oversamples the line at 16x, deframes 8N1 characters (LSB first), and validates start and stop bits.
- Pushes each good byte into a small first-word-fall-through FIFO with a valid/ready output handshake for the bench's checker.
- Flags framing errors (pulse) and FIFO overruns (sticky).

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (default 8 entries).
- SYNC_STAGES, 2, number of rx input synchroniser flops (minimum 2).

Ports:
- wb_clock  input  1  single clock, shared with the Wishbone side.
- wb_rst_i  input  1  reset; asynchronous, active-high.
- rx_i  input  1  serial line (the UART's TX pin); idle level 1.
- divisor_i  input  16  wb_clock cycles per 1/16 bit; value 0 is treated as 1.
- data_o  output  8  FIFO head byte.
- valid_o  output  1  FIFO not empty.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
- framing_err_o  output  1  one-cycle pulse on a bad stop bit.
- overrun_o  output  1  sticky; a byte was dropped because the FIFO was full.
- clr_i  input  1  synchronous clear of overrun_o.
- count_o  output  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset values: data_o=0, valid_o=0, framing_err_o=0, overrun_o=0, count_o=0; synchroniser flops=1; state=IDLE; all counters=0.
- Tick generator: down-counter loads max(divisor_i,1)-1, emits a 1-cycle tick at 0 and reloads. A divisor_i change takes effect at the next reload.
- All deframing uses the synchronised rx (rxs); this adds SYNC_STAGES cycles of input latency.
- Sample counter sc: 4 bits, advances on each tick, wraps 15 -> 0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rxs==0, set sc=0 and go to START. The tick counter is not reset.
- START: on the tick where sc==7 (mid-bit):
  - rxs==1 -> false start, return to IDLE;
  - rxs==0 -> set sc=0, bit index=0, go to DATA.
- DATA: on the tick where sc==15, shift rxs into shift[7] (right shift, LSB first) and increment the bit index. After the 8th bit, set sc=0 and go to STOP.
- STOP: on the tick where sc==15:
  - rxs==1 -> push shift, go to IDLE;
  - rxs==0 -> pulse framing_err_o for 1 cycle, discard the byte, go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. A held-low line produces exactly one framing error.
- The pushed byte appears at data_o / valid_o on the cycle after the stop-bit sample (FWFT).
- FIFO: circular buffer with FIFO_AW-bit pointers that wrap modulo depth.
  - pop = valid_o && ready_i.
  - Push when full and no pop in the same cycle: byte dropped, overrun_o set. Occupancy and contents are unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: the push completes, valid_o rises next cycle, the pop is a no-op since valid_o=0.
  - ready_i while empty: no effect.
- overrun_o: cleared only by clr_i or reset. If clr_i and a new overrun occur in the same cycle, the set wins.
- Reset asserted mid-frame: the FSM aborts immediately and the FIFO empties. After release, a line still low causes IDLE->START; if that frame ends with a bad stop, it is a framing error.

Optional Feature:
- Macro: UART_RX_MONITOR_PARITY_EN.
- Defined:
  - adds input parity_odd_i (1 bit), output parity_err_o (1 bit, 1-cycle pulse, reset 0), and state PARITY between DATA and STOP;
  - parity bit sampled at sc==15;
  - on mismatch with the expected parity (even when parity_odd_i=0), parity_err_o pulses at the stop-bit sample and the byte is discarded;
  - a framing error takes precedence; both pulses may fire together.
- Not defined: frame is 8N1, no parity port or state, DATA goes directly to STOP.

Test Plan:
- divisor_i=1, drive 0xA5 8N1 with 16 clocks/bit, ready_i=1 -> valid_o for 1 cycle with data_o=0xA5; framing_err_o=0; count_o returns to 0.
- Glitch rx_i low for 4 clocks (divisor_i=1) -> false start: no push, FSM back in IDLE; a following frame 0x3C is received correctly.
- Frame 0x55 with stop bit 0, then line held low 100 clocks -> exactly one framing_err_o pulse, count_o=0; after rx_i returns high, next frame 0x0F received.
- ready_i=0, send 9 frames 0x01..0x09 -> count_o=8, overrun_o=1, then drain order 0x01..0x08; clr_i -> overrun_o=0.
- FIFO full, ready_i=1 in the same cycle as the stop sample of a 9th byte -> no overrun, count_o stays 8, 0x09 is last out.
- Assert wb_rst_i at data bit 4 of frame 0xFF -> all outputs 0 immediately; after release, frame 0x81 received cleanly. With UART_RX_MONITOR_PARITY_EN and parity_odd_i=0: 0x07 sent with parity 0 -> parity_err_o pulse, no push.
